// File: rtl/pfb_mac_out_if.sv
// AXI-Stream sample bus leaving the PFB MAC output stage.
// master drives data/valid/last, slave drives ready.
interface pfb_mac_out_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/pfb_mac_out.sv
// PFB MAC cascade output: round, saturate, FIFO, AXI-Stream, ce throttle.
// Define PFB_MAC_OUT_CONVERGENT_EN for round-half-to-even.
module pfb_mac_out #(
    parameter int IN_W       = 48,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int NCHAN      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] p,
    input  logic            p_valid,
    output logic            ce,
    pfb_mac_out_if.master   m,
    output logic            ovf,
    input  logic            ovf_clr
);
    localparam int QW = IN_W + 1 - SHIFT;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int OW = AW + 2;

    localparam logic [IN_W:0] RND =
        (IN_W+1)'(1) << (SHIFT-1);
    localparam logic [SHIFT-1:0] HALF =
        SHIFT'(1) << (SHIFT-1);
    localparam logic [OUT_W-1:0] POS_MAX =
        {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MAX =
        {1'b1, {(OUT_W-1){1'b0}}};

    logic accept;
    assign accept = ce & p_valid;

    logic [CW-1:0] chan;
    logic          chan_end;
    assign chan_end = (chan == CW'(NCHAN-1));

    logic add_rnd;
`ifdef PFB_MAC_OUT_CONVERGENT_EN
    assign add_rnd = (p[SHIFT-1:0] != HALF) | p[SHIFT];
`else
    assign add_rnd = 1'b1;
`endif

    logic [IN_W:0] r_next;
    assign r_next = {p[IN_W-1], p} + (add_rnd ? RND : '0);

    logic [IN_W:0] s1_r;
    logic          s1_valid;
    logic          s1_last;

    logic unused_lsb;
    assign unused_lsb = ^s1_r[SHIFT-1:0] ^ ^HALF;

    // Upper bits of q must all match the output sign bit to fit.
    logic [QW-1:0]      q;
    logic [QW-OUT_W:0]  q_top;
    logic               sat_hi;
    logic               sat_lo;
    logic [OUT_W-1:0]   sat_val;
    assign q      = s1_r[IN_W:SHIFT];
    assign q_top  = q[QW-1:OUT_W-1];
    assign sat_hi = ~q[QW-1] & (|q_top);
    assign sat_lo = q[QW-1] & ~(&q_top);

    always_comb begin
        sat_val = q[OUT_W-1:0];
        unique case (1'b1)
            sat_hi:  sat_val = POS_MAX;
            sat_lo:  sat_val = NEG_MAX;
            default: sat_val = q[OUT_W-1:0];
        endcase
    end

    logic [OUT_W-1:0] s2_data;
    logic             s2_valid;
    logic             s2_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            chan     <= '0;
            s1_r     <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_data  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                chan <= chan_end ? '0 : chan + CW'(1);
            end
            s1_r     <= r_next;
            s1_valid <= accept;
            s1_last  <= accept & chan_end;
            s2_data  <= sat_val;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid & (sat_hi | sat_lo)) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    logic [OUT_W:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic [OW-1:0]   occ_next;
    logic            push;
    logic            pop;

    assign push     = s2_valid;
    assign pop      = m.tvalid & m.tready;
    assign m.tvalid = (count != '0);
    assign m.tdata  = m.tvalid ? mem[rd_ptr][OUT_W-1:0] : '0;
    assign m.tlast  = m.tvalid & mem[rd_ptr][OUT_W];

    assign count_next = count + (AW+1)'(push)
                      - (AW+1)'(pop);
    // Next-cycle occupancy: FIFO plus both stage valids after this edge.
    assign occ_next = OW'(count_next) + OW'(accept)
                    + OW'(s1_valid);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s2_last, s2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ce     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            ce    <= (occ_next < OW'(FIFO_DEPTH-2));
        end
    end
endmodule

// File: tb/tb_pfb_mac_out.sv
// Scoreboard bench for pfb_mac_out with a behavioural rounding model.
// Random data and ready, directed rounding/saturation/latency/reset.
module tb_pfb_mac_out;
    localparam int IN_W       = 48;
    localparam int OUT_W      = 16;
    localparam int SHIFT      = 15;
    localparam int NCHAN      = 64;
    localparam int FIFO_DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [IN_W-1:0] p;
    logic            p_valid;
    logic            ce;
    logic            ovf;
    logic            ovf_clr;

    pfb_mac_out_if #(.OUT_W(OUT_W)) axi ();

    pfb_mac_out #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .NCHAN(NCHAN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .p(p), .p_valid(p_valid),
        .ce(ce), .m(axi), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [OUT_W:0] sb [$];
    int             nacc = 0;
    int             nout = 0;
    int             lastq [$];
    bit             stalled = 0;
    logic [OUT_W:0] held;

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: floor((x + half) / 2^SHIFT), clamp to OUT_W signed.
    function automatic logic [OUT_W:0] model(
        input logic [IN_W-1:0] pv, input int idx);
        longint x, half, frac, base, q, lim;
        logic [63:0] qb;
        x    = longint'($signed(pv));
        half = longint'(1) << (SHIFT-1);
        frac = x & ((longint'(1) << SHIFT) - 1);
        base = x >>> SHIFT;
        q    = (x + half) >>> SHIFT;
`ifdef PFB_MAC_OUT_CONVERGENT_EN
        if (frac == half && (base & 1) == 0) q = base;
`else
        if (frac == half && base == 0) q = (x + half) >>> SHIFT;
`endif
        lim = longint'(1) << (OUT_W-1);
        if (q > lim - 1) q = lim - 1;
        if (q < -lim)    q = -lim;
        qb = q;
        return {(idx % NCHAN) == NCHAN-1, qb[OUT_W-1:0]};
    endfunction

    always @(negedge clk) begin
        logic [OUT_W:0] e;
        if (rst) begin
            sb.delete();
            lastq.delete();
            nacc    = 0;
            nout    = 0;
            stalled = 0;
        end else begin
            if (stalled && axi.tvalid) begin
                check("hold_data", axi.tdata, held[OUT_W-1:0]);
                check("hold_last", axi.tlast, held[OUT_W]);
            end
            if (ce && p_valid) begin
                sb.push_back(model(p, nacc));
                nacc++;
            end
            if (axi.tvalid && axi.tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("tdata", axi.tdata, e[OUT_W-1:0]);
                    check("tlast", axi.tlast, e[OUT_W]);
                end
                if (axi.tlast) lastq.push_back(nout);
                nout++;
            end
            if (ce && p_valid)
                check("occ_limit", sb.size() > FIFO_DEPTH-2, 0);
            stalled = axi.tvalid && !axi.tready;
            held    = {axi.tlast, axi.tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [IN_W-1:0] v);
        bit took;
        int n;
        took = 0;
        n = 0;
        p = v;
        p_valid = 1;
        while (!took && n < 100) begin
            took = ce;
            tick();
            n++;
        end
        p_valid = 0;
        if (!took) check("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        axi.tready = 1;
        while (sb.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    function automatic logic [IN_W-1:0] rand_p();
        longint v;
        logic [63:0] b;
        if ($urandom_range(0, 3) == 0) begin
            b = {$urandom, $urandom};
        end else begin
            v = longint'($signed($urandom));
            v = v >>> $urandom_range(0, 16);
            b = v;
        end
        return b[IN_W-1:0];
    endfunction

    task automatic check_lasts(input int n, input int exp0);
        check("nlast", lastq.size(), n);
        for (int i = 0; i < n; i++)
            check("last_pos",
                  (i < lastq.size()) ? lastq[i] : -1,
                  exp0 + NCHAN * i);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int nsent;
        int guard;
        bit was;
        rst = 1;
        p = '0;
        p_valid = 0;
        ovf_clr = 0;
        axi.tready = 0;
        repeat (3) tick();
        check("rst_ce", ce, 0);
        check("rst_tvalid", axi.tvalid, 0);
        check("rst_tlast", axi.tlast, 0);
        check("rst_tdata", axi.tdata, 0);
        check("rst_ovf", ovf, 0);
        rst = 0;
        #1;
        check("ce_before_edge", ce, 0);
        tick();
        check("ce_after_rst", ce, 1);

        axi.tready = 1;
        send_one(48'd5 << 15);
        check("lat_k0", axi.tvalid, 0);
        tick();
        check("lat_k1", axi.tvalid, 0);
        tick();
        check("lat_k2", axi.tvalid, 1);
        check("lat_data", axi.tdata, 5);
        wait_drain();

        send_one(48'h0000_0000_4000);
        send_one(48'h0000_0000_C000);
        send_one(48'hFFFF_FFFF_C000);
        wait_drain();

        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        check("ovf_clear0", ovf, 0);
        send_one(48'h0000_8000_0000);
        tick();
        tick();
        check("ovf_set", ovf, 1);
        send_one(48'hFFFF_8000_0000);
        send_one(48'h0000_3FFF_8000);
        repeat (5) tick();
        check("ovf_sticky", ovf, 1);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        check("ovf_cleared", ovf, 0);
        send_one(48'h0000_8000_0000);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        check("ovf_set_wins", ovf, 1);
        wait_drain();

        axi.tready = 0;
        p_valid = 1;
        repeat (40) begin
            p = rand_p();
            tick();
        end
        p_valid = 0;
        check("bp_ce_low", ce, 0);
        check("bp_occ", sb.size(), FIFO_DEPTH-2);
        check("bp_tvalid", axi.tvalid, 1);
        wait_drain();

        repeat (400) begin
            p = rand_p();
            p_valid = ($urandom_range(0, 3) != 0);
            axi.tready = $urandom_range(0, 1);
            tick();
        end
        p_valid = 0;
        wait_drain();

        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
        nsent = 0;
        guard = 0;
        while (nsent < 3 * NCHAN && guard < 5000) begin
            p = rand_p();
            p_valid = $urandom_range(0, 1);
            axi.tready = $urandom_range(0, 1);
            was = ce && p_valid;
            tick();
            if (was) nsent++;
            guard++;
        end
        p_valid = 0;
        check("frame_sent", nsent, 3 * NCHAN);
        wait_drain();
        check_lasts(3, NCHAN - 1);

        axi.tready = 0;
        repeat (5) send_one(rand_p());
        repeat (3) tick();
        check("mid_tvalid", axi.tvalid, 1);
        rst = 1;
        tick();
        check("mid_rst_tvalid", axi.tvalid, 0);
        check("mid_rst_ce", ce, 0);
        check("mid_rst_tdata", axi.tdata, 0);
        rst = 0;
        tick();
        check("mid_ce_back", ce, 1);
        axi.tready = 1;
        repeat (NCHAN) send_one(rand_p());
        wait_drain();
        check_lasts(1, NCHAN - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
